// File: rtl/gray_conv_arbiter_if.sv
// Request/result bus for gray_conv_arbiter: NREQ requesters in, one converted word out.
// The out_par wire exists only when GRAY_CONV_ARB_PARITY_EN is defined.
interface gray_conv_arbiter_if #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_mode;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [IDW-1:0]    out_id;
  logic              out_mode;
`ifdef GRAY_CONV_ARB_PARITY_EN
  logic              out_par;
`endif

  // master: requesters plus downstream consumer; slave: the arbiter itself
  modport master (
    output req_valid, req_mode, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_mode
`ifdef GRAY_CONV_ARB_PARITY_EN
    , input out_par
`endif
  );

  modport slave (
    input  req_valid, req_mode, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, out_mode
`ifdef GRAY_CONV_ARB_PARITY_EN
    , output out_par
`endif
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared binary<->Gray converter with a single registered output slot.
// Optional macro GRAY_CONV_ARB_PARITY_EN adds a registered out_par (XOR of out_data).
module gray_conv_arbiter #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic               clk,
  input logic               rst_n,
  gray_conv_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_reg;
  logic [IDW-1:0] rr_ptr_reg;
  logic           out_valid_reg;
  logic [W-1:0]   out_data_reg;
  logic [IDW-1:0] out_id_reg;
  logic           out_mode_reg;

  logic [W-1:0]    data_arr [NREQ];
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            found;
  logic            can_load;
  logic [NREQ-1:0] ready_w;
  logic            any_grant;
  logic [IDW-1:0]  ptr_next;
  logic [W-1:0]    sel_data;
  logic            sel_mode;
  logic [W-1:0]    gray_w;
  logic [W-1:0]    bin_w;
  logic [W-1:0]    conv_w;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NREQ) ? s - NREQ : s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = bus.req_data[gi*W +: W];
    end
  endgenerate

  // Rotating priority search starting at rr_ptr_reg; first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && bus.req_valid[wrap_idx(int'(rr_ptr_reg), off)]) begin
        found = 1'b1;
        grant[wrap_idx(int'(rr_ptr_reg), off)] = 1'b1;
        grant_idx = IDW'(wrap_idx(int'(rr_ptr_reg), off));
      end
    end
  end

  assign can_load      = (state_reg == EMPTY) | bus.out_ready;
  assign ready_w       = (rst_n && can_load) ? grant : '0;
  assign any_grant     = |ready_w;
  assign bus.req_ready = ready_w;
  assign ptr_next      = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  // One-hot AND-OR select of the granted word and direction.
  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | data_arr[i];
        sel_mode = sel_mode | bus.req_mode[i];
      end
    end
  end

  // Gray->bin bit i is the XOR of all input bits from the MSB down to i.
  generate
    for (gi = 0; gi < W; gi++) begin : g_conv
      if (gi == W - 1) begin : g_msb
        assign gray_w[gi] = sel_data[gi];
      end else begin : g_lsb
        assign gray_w[gi] = sel_data[gi+1] ^ sel_data[gi];
      end
      assign bin_w[gi] = ^sel_data[W-1:gi];
    end
  endgenerate

  assign conv_w = sel_mode ? bin_w : gray_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      rr_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
      out_mode_reg  <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (any_grant) begin
            state_reg     <= FULL;
            out_valid_reg <= 1'b1;
          end
        end
        FULL: begin
          if (bus.out_ready && !any_grant) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          out_valid_reg <= 1'b0;
        end
      endcase
      if (any_grant) begin
        rr_ptr_reg   <= ptr_next;
        out_data_reg <= conv_w;
        out_id_reg   <= grant_idx;
        out_mode_reg <= sel_mode;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_id    = out_id_reg;
  assign bus.out_mode  = out_mode_reg;

`ifdef GRAY_CONV_ARB_PARITY_EN
  logic out_par_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_par_reg <= 1'b0;
    end else if (any_grant) begin
      out_par_reg <= ^conv_w;
    end
  end

  assign bus.out_par = out_par_reg;
`endif

endmodule
